// File: rtl/unidad_mult_div_if.sv
// Handshake and data bundle for the iterative multiply/divide unit.
// The requester drives the master side and the unit drives the slave side.
interface unidad_mult_div_if;
  logic        inicio;
  logic        op;
  logic [31:0] operandoA;
  logic [31:0] operandoB;
  logic        ocupado;
  logic        listo;
  logic        div_cero;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output inicio, op, operandoA, operandoB,
    input  ocupado, listo, div_cero, hi, lo
  );

  modport slave (
    input  inicio, op, operandoA, operandoB,
    output ocupado, listo, div_cero, hi, lo
  );
endinterface

// File: rtl/unidad_mult_div.sv
// Unsigned 32x32 multiply (shift-add) and divide (restoring), one iteration per cycle.
// Latency 33 cycles accept-to-listo, 2 for divide by zero; inicio is ignored while busy.
module unidad_mult_div (
  input  logic               clk,
  input  logic               rst_n,
  unidad_mult_div_if.slave   bus
);

  typedef enum logic [1:0] {ESPERA, CALCULO, FIN} estado_t;

  estado_t     estado;
  logic [4:0]  contador;
  logic        op_r;
  logic [31:0] a_r;
  logic [31:0] b_r;
  logic [31:0] parc_hi;
  logic [31:0] parc_lo;
  logic [31:0] hi_r;
  logic [31:0] lo_r;
  logic        div_cero_r;
  logic        ocupado_r;
  logic        listo_r;

  logic [32:0] suma;
  logic [32:0] desp;
  logic [33:0] resta;
  logic [31:0] sig_hi;
  logic [31:0] sig_lo;

  // One step of whichever algorithm is latched; parc_hi/parc_lo double as
  // product halves (multiply) or remainder/quotient (divide).
  always_comb begin
    suma   = {1'b0, parc_hi} + (parc_lo[0] ? {1'b0, a_r} : 33'd0);
    desp   = {parc_hi, parc_lo[31]};
    resta  = {1'b0, desp} - {2'b00, b_r};
    sig_hi = suma[32:1];
    sig_lo = {suma[0], parc_lo[31:1]};
    if (op_r) begin
      if (!resta[33]) begin
        sig_hi = resta[31:0];
        sig_lo = {parc_lo[30:0], 1'b1};
      end else begin
        sig_hi = desp[31:0];
        sig_lo = {parc_lo[30:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      estado     <= ESPERA;
      contador   <= 5'd0;
      op_r       <= 1'b0;
      a_r        <= 32'd0;
      b_r        <= 32'd0;
      parc_hi    <= 32'd0;
      parc_lo    <= 32'd0;
      hi_r       <= 32'd0;
      lo_r       <= 32'd0;
      div_cero_r <= 1'b0;
      ocupado_r  <= 1'b0;
      listo_r    <= 1'b0;
    end else begin
      case (estado)
        ESPERA: begin
          listo_r <= 1'b0;
          if (bus.inicio) begin
            op_r      <= bus.op;
            a_r       <= bus.operandoA;
            b_r       <= bus.operandoB;
            parc_hi   <= 32'd0;
            parc_lo   <= bus.op ? bus.operandoA : bus.operandoB;
            contador  <= 5'd0;
            ocupado_r <= 1'b1;
            estado    <= CALCULO;
          end
        end
        CALCULO: begin
          if (op_r && (b_r == 32'd0)) begin
            hi_r       <= a_r;
            lo_r       <= 32'hFFFF_FFFF;
            div_cero_r <= 1'b1;
            ocupado_r  <= 1'b0;
            listo_r    <= 1'b1;
            estado     <= FIN;
          end else begin
            parc_hi  <= sig_hi;
            parc_lo  <= sig_lo;
            contador <= contador + 5'd1;
            if (contador == 5'd31) begin
              hi_r       <= sig_hi;
              lo_r       <= sig_lo;
              div_cero_r <= 1'b0;
              ocupado_r  <= 1'b0;
              listo_r    <= 1'b1;
              estado     <= FIN;
            end
          end
        end
        FIN: begin
          listo_r <= 1'b0;
          estado  <= ESPERA;
        end
        default: begin
          ocupado_r <= 1'b0;
          listo_r   <= 1'b0;
          estado    <= ESPERA;
        end
      endcase
    end
  end

  assign bus.ocupado  = ocupado_r;
  assign bus.listo    = listo_r;
  assign bus.div_cero = div_cero_r;
  assign bus.hi       = hi_r;
  assign bus.lo       = lo_r;

endmodule

// File: tb/tb_unidad_mult_div.sv
// Directed vectors plus hand-written sequences for the multiply/divide unit.
module tb_unidad_mult_div;

  logic clk;
  logic rst_n;
  unidad_mult_div_if bus ();

  unidad_mult_div dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp;
  int n_fail;

  typedef struct {
    logic        op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
    logic        exp_dz;
    int          exp_lat;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic wait_listo(input string nm, output int lat);
    lat = 1;
    while (bus.listo !== 1'b1 && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    if (lat >= 100) chk({nm, " timeout"}, 64'd1, 64'd0);
  endtask

  // Starts an operation, scrambles the operands after accept, waits for listo.
  task automatic run_op(input string nm, input logic o, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] rhi, output logic [31:0] rlo,
                        output logic rdz, output int lat);
    logic [31:0] prev_hi, prev_lo;
    int cambios;
    @(negedge clk);
    prev_hi = bus.hi;
    prev_lo = bus.lo;
    bus.op = o; bus.operandoA = a; bus.operandoB = b; bus.inicio = 1'b1;
    @(negedge clk);
    bus.inicio = 1'b0;
    bus.operandoA = $urandom;
    bus.operandoB = $urandom;
    bus.op = ~o;
    cambios = 0;
    lat = 1;
    while (bus.listo !== 1'b1 && lat < 100) begin
      if (bus.hi !== prev_hi || bus.lo !== prev_lo) cambios++;
      @(negedge clk);
      lat++;
    end
    rhi = bus.hi;
    rlo = bus.lo;
    rdz = bus.div_cero;
    chk({nm, " partial exposed"}, 64'(cambios), 64'd0);
    @(negedge clk);
    chk({nm, " listo single"}, {63'd0, bus.listo}, 64'd0);
  endtask

  logic [31:0] rhi, rlo;
  logic        rdz;
  int          lat, pulses;
  logic [31:0] cap_hi, cap_lo;

  initial begin
    n_cmp = 0;
    n_fail = 0;
    vecs[0] = '{1'b0, 32'd45,         32'd50,         32'd0,          32'd2250,       1'b0, 33};
    vecs[1] = '{1'b0, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFE,  32'h0000_0001,  1'b0, 33};
    vecs[2] = '{1'b1, 32'd132,        32'd7,          32'd6,          32'd18,         1'b0, 33};
    vecs[3] = '{1'b1, 32'd94,         32'd0,          32'd94,         32'hFFFF_FFFF,  1'b1, 2};
    vecs[4] = '{1'b1, 32'd127,        32'h2,          32'd1,          32'd63,         1'b0, 33};
    vecs[5] = '{1'b0, 32'h1234_5678,  32'h10,         32'h1,          32'h2345_6780,  1'b0, 33};
    vecs[6] = '{1'b1, 32'd7,          32'd9,          32'd7,          32'd0,          1'b0, 33};
    vecs[7] = '{1'b1, 32'hFFFF_FFFF,  32'd1,          32'd0,          32'hFFFF_FFFF,  1'b0, 33};
    vecs[8] = '{1'b1, 32'd5,          32'd0,          32'd5,          32'hFFFF_FFFF,  1'b1, 2};
    vecs[9] = '{1'b0, 32'd0,          32'd5,          32'd0,          32'd0,          1'b0, 33};

    // Reset with inicio asserted: nothing may start.
    rst_n = 1'b0;
    bus.inicio = 1'b1; bus.op = 1'b0; bus.operandoA = 32'd5; bus.operandoB = 32'd5;
    repeat (3) @(negedge clk);
    chk("reset ocupado",  {63'd0, bus.ocupado},  64'd0);
    chk("reset listo",    {63'd0, bus.listo},    64'd0);
    chk("reset div_cero", {63'd0, bus.div_cero}, 64'd0);
    chk("reset hi", {32'd0, bus.hi}, 64'd0);
    chk("reset lo", {32'd0, bus.lo}, 64'd0);
    bus.inicio = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 10; i++) begin
      run_op($sformatf("v%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, rhi, rlo, rdz, lat);
      chk($sformatf("v%0d latency", i), 64'(lat), 64'(vecs[i].exp_lat));
      chk($sformatf("v%0d hi", i), {32'd0, rhi}, {32'd0, vecs[i].exp_hi});
      chk($sformatf("v%0d lo", i), {32'd0, rlo}, {32'd0, vecs[i].exp_lo});
      chk($sformatf("v%0d div_cero", i), {63'd0, rdz}, {63'd0, vecs[i].exp_dz});
    end

    // inicio pulsed mid-multiply with new operands must be ignored.
    @(negedge clk);
    bus.op = 1'b0; bus.operandoA = 32'd1000; bus.operandoB = 32'd3; bus.inicio = 1'b1;
    @(negedge clk);
    bus.inicio = 1'b0;
    pulses = 0; cap_hi = '0; cap_lo = '0;
    for (int c = 2; c <= 45; c++) begin
      @(negedge clk);
      if (bus.listo === 1'b1) begin
        pulses++;
        cap_hi = bus.hi;
        cap_lo = bus.lo;
      end
      if (c == 10) begin
        bus.inicio = 1'b1; bus.operandoA = 32'd7; bus.operandoB = 32'd7;
      end
      if (c == 11) bus.inicio = 1'b0;
    end
    chk("ignore inicio pulses", 64'(pulses), 64'd1);
    chk("ignore inicio lo", {32'd0, cap_lo}, 64'd3000);
    chk("ignore inicio hi", {32'd0, cap_hi}, 64'd0);
    chk("ignore inicio idle", {63'd0, bus.ocupado}, 64'd0);

    // Reset at cycle 20 of a divide aborts it.
    bus.op = 1'b1; bus.operandoA = 32'd1000; bus.operandoB = 32'd3; bus.inicio = 1'b1;
    @(negedge clk);
    bus.inicio = 1'b0;
    repeat (19) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort ocupado", {63'd0, bus.ocupado}, 64'd0);
    chk("abort listo",   {63'd0, bus.listo},   64'd0);
    chk("abort hi", {32'd0, bus.hi}, 64'd0);
    chk("abort lo", {32'd0, bus.lo}, 64'd0);
    rst_n = 1'b1;
    pulses = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (bus.listo === 1'b1) pulses++;
    end
    chk("abort no listo", 64'(pulses), 64'd0);
    run_op("post-reset mul", 1'b0, 32'd12, 32'd2, rhi, rlo, rdz, lat);
    chk("post-reset lo", {32'd0, rlo}, 64'd24);
    chk("post-reset latency", 64'(lat), 64'd33);

    // inicio held high restarts on the first ESPERA edge after FIN.
    @(negedge clk);
    bus.op = 1'b0; bus.operandoA = 32'd3; bus.operandoB = 32'd4; bus.inicio = 1'b1;
    @(negedge clk);
    bus.operandoA = 32'd5; bus.operandoB = 32'd6;
    wait_listo("held first", lat);
    chk("held first lo", {32'd0, bus.lo}, 64'd12);
    @(negedge clk);
    chk("held idle gap", {63'd0, bus.ocupado}, 64'd0);
    @(negedge clk);
    chk("held restart", {63'd0, bus.ocupado}, 64'd1);
    bus.inicio = 1'b0;
    wait_listo("held second", lat);
    chk("held second lo", {32'd0, bus.lo}, 64'd30);
    chk("held second latency", 64'(lat), 64'd33);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
